// File: rtl/u_control_pkg.sv
// Shared types for the shift-and-add multiplier controller: state encoding
// and the bundle of registered datapath strobes.
package u_control_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int unsigned N_ITER = 4;

  // add marks the ADD state; wsumh/wc are gated by q0 outside the register.
  typedef struct packed {
    logic wa;
    logic wsuml;
    logic clinicio;
    logic clc;
    logic add;
    logic shrsum;
    logic upcont;
    logic busy;
    logic done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S_LOAD: begin
        c.wa       = 1'b1;
        c.wsuml    = 1'b1;
        c.clinicio = 1'b1;
        c.clc      = 1'b1;
        c.busy     = 1'b1;
      end
      S_ADD: begin
        c.add  = 1'b1;
        c.busy = 1'b1;
      end
      // clc alongside shrsum is safe: C feeds the shift-in before it clears.
      S_SHIFT: begin
        c.shrsum = 1'b1;
        c.upcont = 1'b1;
        c.clc    = 1'b1;
        c.busy   = 1'b1;
      end
      S_DONE:  c.done = 1'b1;
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/u_control.sv
// Controller for the 4-bit shift-and-add multiplier: start/done handshake,
// operand load and four ADD/SHIFT iterations driving the u_datos strobes.
module u_control
  import u_control_pkg::*;
#(
  parameter bit HOLD_DONE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic q0,
  input  logic cycont,
  output logic wa,
  output logic wsuml,
  output logic clinicio,
  output logic clc,
  output logic wsumh,
  output logic wc,
  output logic shrsum,
  output logic upcont,
  output logic busy,
  output logic done
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl_q;

  // NOTE: every path assigns state_d after the default, so no latch is inferred.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_ADD;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = cycont ? S_DONE : S_ADD;
      S_DONE:  state_d = (HOLD_DONE && start) ? S_DONE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they are registered yet
  // aligned with the state they belong to.
  // NOTE: non-blocking assignments keep state and strobes updating together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= CTRL_IDLE;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  assign wa       = ctrl_q.wa;
  assign wsuml    = ctrl_q.wsuml;
  assign clinicio = ctrl_q.clinicio;
  assign clc      = ctrl_q.clc;
  assign shrsum   = ctrl_q.shrsum;
  assign upcont   = ctrl_q.upcont;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;

  // In ADD the datapath is written only when the multiplier bit is set.
  assign wsumh    = ctrl_q.add & q0;
  assign wc       = ctrl_q.add & q0;

endmodule

// File: tb/tb_u_control.sv
// Directed bench for u_control: two instances (held and pulsed done) each
// driving a behavioural u_datos model whose product is checked against a*b.
module tb_u_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start_v;
  logic [3:0] datoa, datob;

  logic [1:0] q0_w, cycont_w, wa_w, wsuml_w, clinicio_w, clc_w;
  logic [1:0] wsumh_w, wc_w, shrsum_w, upcont_w, busy_w, done_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  u_control #(.HOLD_DONE(1'b1)) dut_hold (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .q0(q0_w[0]), .cycont(cycont_w[0]),
    .wa(wa_w[0]), .wsuml(wsuml_w[0]), .clinicio(clinicio_w[0]), .clc(clc_w[0]),
    .wsumh(wsumh_w[0]), .wc(wc_w[0]), .shrsum(shrsum_w[0]), .upcont(upcont_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  u_control #(.HOLD_DONE(1'b0)) dut_pulse (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .q0(q0_w[1]), .cycont(cycont_w[1]),
    .wa(wa_w[1]), .wsuml(wsuml_w[1]), .clinicio(clinicio_w[1]), .clc(clc_w[1]),
    .wsumh(wsumh_w[1]), .wc(wc_w[1]), .shrsum(shrsum_w[1]), .upcont(upcont_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  // Behavioural datapath: A, {C,SUMH,SUML} and a 2-bit iteration counter.
  logic [3:0] a_r [2];
  logic [3:0] sumh [2];
  logic [3:0] suml [2];
  logic       c_r [2];
  logic [1:0] cnt [2];
  int shr_n [2], up_n [2], wsumh_n [2], wc_n [2];
  bit viol [2];

  for (genvar g = 0; g < 2; g++) begin : g_links
    assign q0_w[g]     = suml[g][0];
    assign cycont_w[g] = (cnt[g] == 2'd3);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0] sum;
      sum = {1'b0, sumh[i]} + {1'b0, a_r[i]};
      if (wa_w[i]) a_r[i] <= datoa;
      if (shrsum_w[i]) {sumh[i], suml[i]} <= {c_r[i], sumh[i], suml[i][3:1]};
      else begin
        if (wsuml_w[i]) suml[i] <= datob;
        if (clinicio_w[i]) sumh[i] <= 4'd0;
        else if (wsumh_w[i]) sumh[i] <= sum[3:0];
      end
      if (wc_w[i]) c_r[i] <= sum[4];
      else if (clc_w[i]) c_r[i] <= 1'b0;
      if (upcont_w[i]) cnt[i] <= cnt[i] + 2'd1;
      else if (clinicio_w[i]) cnt[i] <= 2'd0;
      if (wa_w[i]) begin
        shr_n[i] <= 0; up_n[i] <= 0; wsumh_n[i] <= 0; wc_n[i] <= 0;
      end else begin
        if (shrsum_w[i]) shr_n[i] <= shr_n[i] + 1;
        if (upcont_w[i]) up_n[i] <= up_n[i] + 1;
        if (wsumh_w[i]) wsumh_n[i] <= wsumh_n[i] + 1;
        if (wc_w[i]) wc_n[i] <= wc_n[i] + 1;
      end
      if ((upcont_w[i] && clinicio_w[i]) || (wsumh_w[i] && shrsum_w[i])) viol[i] <= 1'b1;
    end
  end

  function automatic logic [9:0] outs(input int s);
    return {wa_w[s], wsuml_w[s], clinicio_w[s], clc_w[s], wsumh_w[s], wc_w[s],
            shrsum_w[s], upcont_w[s], busy_w[s], done_w[s]};
  endfunction

  function automatic logic [7:0] result(input int s);
    return {sumh[s], suml[s]};
  endfunction

  // Start an operation and wait (bounded) for done, counting busy cycles.
  task automatic run_op(input int sel, input logic [3:0] a, input logic [3:0] b,
                        input bit hold, output int nbusy, output bit seen);
    @(negedge clk);
    datoa = a; datob = b; start_v[sel] = 1'b1;
    @(negedge clk);
    if (!hold) start_v[sel] = 1'b0;
    nbusy = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_w[sel]) begin
        seen = 1'b1;
        break;
      end
      if (busy_w[sel]) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_v = 2'b00; datoa = 4'd0; datob = 4'd0;
    viol[0] = 1'b0; viol[1] = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (outs(s) !== 10'd0) begin
        errors++; $display("FAIL reset_outs[%0d]: got %b expected 0", s, outs(s));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_hold_5x3;
    int nb; bit seen;
    run_op(0, 4'd5, 4'd3, 1'b1, nb, seen);
    checks++; if (!seen) begin errors++; $display("FAIL 5x3_done: got no done expected done"); end
    checks++; if (nb != 9) begin errors++; $display("FAIL 5x3_busy: got %0d expected 9", nb); end
    checks++; if (result(0) !== 8'd15) begin errors++; $display("FAIL 5x3_result: got %0d expected 15", result(0)); end
    checks++; if (shr_n[0] != 4 || up_n[0] != 4) begin
      errors++; $display("FAIL 5x3_pulses: got shr=%0d up=%0d expected 4/4", shr_n[0], up_n[0]);
    end
    repeat (3) @(negedge clk);
    checks++; if (done_w[0] !== 1'b1) begin errors++; $display("FAIL 5x3_done_held: got %b expected 1", done_w[0]); end
    start_v[0] = 1'b0;
    @(negedge clk);
    checks++; if (outs(0) !== 10'd0) begin errors++; $display("FAIL 5x3_idle: got %b expected 0", outs(0)); end
  endtask

  task automatic test_carry_15x15;
    int nb; bit seen;
    run_op(0, 4'd15, 4'd15, 1'b0, nb, seen);
    checks++; if (!seen || result(0) !== 8'd225) begin
      errors++; $display("FAIL 15x15_result: got %0d (done=%b) expected 225", result(0), seen);
    end
    checks++; if (wc_n[0] != 4) begin errors++; $display("FAIL 15x15_wc: got %0d expected 4", wc_n[0]); end
    checks++; if (c_r[0] !== 1'b0) begin errors++; $display("FAIL 15x15_c_cleared: got %b expected 0", c_r[0]); end
  endtask

  task automatic test_zero;
    int nb; bit seen;
    run_op(0, 4'd0, 4'd9, 1'b0, nb, seen);
    checks++; if (!seen || result(0) !== 8'd0) begin
      errors++; $display("FAIL 0x9_result: got %0d (done=%b) expected 0", result(0), seen);
    end
    checks++; if (wsumh_n[0] != 2) begin errors++; $display("FAIL 0x9_wsumh: got %0d expected 2", wsumh_n[0]); end
    run_op(0, 4'd9, 4'd0, 1'b0, nb, seen);
    checks++; if (!seen || result(0) !== 8'd0) begin
      errors++; $display("FAIL 9x0_result: got %0d (done=%b) expected 0", result(0), seen);
    end
    checks++; if (wsumh_n[0] != 0) begin errors++; $display("FAIL 9x0_wsumh: got %0d expected 0", wsumh_n[0]); end
  endtask

  task automatic test_back_to_back;
    int nb; bit seen;
    run_op(1, 4'd7, 4'd6, 1'b0, nb, seen);
    checks++; if (!seen || result(1) !== 8'd42) begin
      errors++; $display("FAIL b2b_7x6: got %0d (done=%b) expected 42", result(1), seen);
    end
    checks++; if (nb != 9) begin errors++; $display("FAIL b2b_busy: got %0d expected 9", nb); end
    @(negedge clk);
    checks++; if (outs(1) !== 10'd0) begin errors++; $display("FAIL b2b_pulse: got %b expected 0", outs(1)); end
    run_op(1, 4'd2, 4'd11, 1'b0, nb, seen);
    checks++; if (!seen || result(1) !== 8'd22) begin
      errors++; $display("FAIL b2b_2x11: got %0d (done=%b) expected 22", result(1), seen);
    end
    checks++; if (shr_n[1] != 4 || up_n[1] != 4) begin
      errors++; $display("FAIL b2b_pulses: got shr=%0d up=%0d expected 4/4", shr_n[1], up_n[1]);
    end
  endtask

  task automatic test_reset_mid;
    int nb; bit seen;
    @(negedge clk);
    datoa = 4'd13; datob = 4'd7; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (shrsum_w[0] !== 1'b1) begin errors++; $display("FAIL mid_in_shift: got %b expected 1", shrsum_w[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (outs(0) !== 10'd0) begin errors++; $display("FAIL mid_reset_outs: got %b expected 0", outs(0)); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 4'd6, 4'd9, 1'b1, nb, seen);
    checks++; if (!seen || result(0) !== 8'd54) begin
      errors++; $display("FAIL mid_6x9: got %0d (done=%b) expected 54", result(0), seen);
    end
    checks++; if (nb != 9) begin errors++; $display("FAIL mid_busy: got %0d expected 9", nb); end
    start_v[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_protocol;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (viol[s]) begin errors++; $display("FAIL strobe_overlap[%0d]: got 1 expected 0", s); end
    end
  endtask

  initial begin
    test_reset();
    test_hold_5x3();
    test_carry_15x15();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
